seg7_scan_ctrl: RTL and testbench

- Avalon-MM slave that drives a 4-digit multiplexed 7-segment display from one shared 7-bit segment bus.
- Holds one raw segment pattern per digit and time-slices the bus across digit enables at a programmable rate.
- Inserts an anti-ghosting blank window at each digit change and supports per-digit blinking for alarm indication.
- Sits on the Nios system interconnect beside the simple output PIOs and replaces direct CPU bit-banging of the display.

---
 rtl/seg7_scan_pkg.sv | 30 +++
 rtl/seg7_scan_timer.sv | 77 +++++++
 rtl/seg7_scan_ctrl.sv | 109 ++++++++++
 tb/tb_seg7_scan_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_scan_pkg.sv
// ============================================================================
// seg7_scan_pkg: register map, CTRL field positions and blank patterns
// Revision: 1.0
// ============================================================================
`default_nettype none

package seg7_scan_pkg;

  localparam logic [2:0] ADDR_DIGIT0 = 3'd0;
  localparam logic [2:0] ADDR_DIGIT1 = 3'd1;
  localparam logic [2:0] ADDR_DIGIT2 = 3'd2;
  localparam logic [2:0] ADDR_DIGIT3 = 3'd3;
  localparam logic [2:0] ADDR_CTRL   = 3'd4;
  localparam logic [2:0] ADDR_STATUS = 3'd5;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_BLINK_EN = 1;
  localparam int CTRL_MASK_LSB = 4;
  localparam int CTRL_MASK_MSB = 7;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] DIG_OFF = 4'hF;

  function automatic logic [3:0] digit_sel_n(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_scan_timer.sv
// ============================================================================
// seg7_scan_timer: slot prescaler, digit index, frame counter and blink phase
// Revision: 1.0
// ============================================================================
`default_nettype none

module seg7_scan_timer #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 16,
  parameter int BLINK_FRAMES = 25
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable_i,
  output logic [1:0] idx_o,
  output logic       blank_o,
  output logic       phase_o
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int FW = $clog2(BLINK_FRAMES + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] PRESC_BLANK = PW'(BLANK_CYCLES);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  logic [FW-1:0] frame_q, frame_d;
  logic          phase_q, phase_d;

  always_comb begin
    presc_d = presc_q + PW'(1);
    idx_d   = idx_q;
    frame_d = frame_q;
    phase_d = phase_q;
    if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      idx_d   = idx_q + 2'd1;
      if (idx_q == 2'd3) begin
        if (frame_q == FRAME_LAST) begin
          frame_d = '0;
          phase_d = ~phase_q;
        end else begin
          frame_d = frame_q + FW'(1);
        end
      end
    end
    // Disabled scanning parks everything at the start of a visible frame.
    if (!enable_i) begin
      presc_d = '0;
      idx_d   = 2'd0;
      frame_d = '0;
      phase_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
      idx_q   <= 2'd0;
      frame_q <= '0;
      phase_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      phase_q <= phase_d;
    end
  end

  assign idx_o   = idx_q;
  assign blank_o = (presc_q < PRESC_BLANK);
  assign phase_o = phase_q;

endmodule

`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
// ============================================================================
// seg7_scan_ctrl: Avalon-MM 4-digit multiplexed 7-segment scan controller
// Revision: 1.0
// ============================================================================
`default_nettype none

module seg7_scan_ctrl
  import seg7_scan_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 16,
  parameter int BLINK_FRAMES = 25
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [6:0]  seg_out_n,
  output logic [3:0]  digit_en_n
);

  logic [NUM_DIGITS-1:0][6:0] digit_q;
  logic                       en_q, blink_en_q;
  logic [3:0]                 mask_q;
  logic [6:0]                 seg_q, seg_d;
  logic [3:0]                 dig_q, dig_d;
  logic [1:0]                 idx_w;
  logic                       blank_w, phase_w;
  logic                       we_w, ctrl_we_w, en_next_w;
  logic                       unused_wdata_w;

  assign we_w           = chipselect & ~write_n;
  assign ctrl_we_w      = we_w && (address == ADDR_CTRL);
  assign en_next_w      = ctrl_we_w ? writedata[CTRL_EN] : en_q;
  assign unused_wdata_w = ^{writedata[31:8], writedata[3:2]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      digit_q    <= '0;
      en_q       <= 1'b0;
      blink_en_q <= 1'b0;
      mask_q     <= 4'h0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (we_w && address == 3'(i)) digit_q[i] <= writedata[6:0];
      end
      if (ctrl_we_w) begin
        en_q       <= writedata[CTRL_EN];
        blink_en_q <= writedata[CTRL_BLINK_EN];
        mask_q     <= writedata[CTRL_MASK_MSB:CTRL_MASK_LSB];
      end
    end
  end

  // Counting only while EN is set both now and next cycle lets a disable write
  // clear the counters on the same edge and makes enable start at prescaler 0.
  seg7_scan_timer #(
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYCLES (BLANK_CYCLES),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable_i (en_q & en_next_w),
    .idx_o    (idx_w),
    .blank_o  (blank_w),
    .phase_o  (phase_w)
  );

  always_comb begin
    readdata = 32'd0;
    case (address)
      ADDR_DIGIT0, ADDR_DIGIT1, ADDR_DIGIT2, ADDR_DIGIT3:
        readdata = {25'd0, digit_q[address[1:0]]};
      ADDR_CTRL:   readdata = {24'd0, mask_q, 2'b00, blink_en_q, en_q};
      ADDR_STATUS: readdata = {29'd0, phase_w, idx_w};
      default:     readdata = 32'd0;
    endcase
  end

  always_comb begin
    dig_d = DIG_OFF;
    seg_d = SEG_OFF;
    if (en_q && !blank_w) begin
      dig_d = digit_sel_n(idx_w);
      if (!(blink_en_q && phase_w && mask_q[idx_w])) seg_d = ~digit_q[idx_w];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_q <= SEG_OFF;
      dig_q <= DIG_OFF;
    end else begin
      seg_q <= seg_d;
      dig_q <= dig_d;
    end
  end

  assign seg_out_n  = seg_q;
  assign digit_en_n = dig_q;

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
// ============================================================================
// tb_seg7_scan_ctrl: randomized self-checking bench against a timing model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_seg7_scan_ctrl;

  localparam int SD = 8;
  localparam int BC = 2;
  localparam int BF = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [6:0]  seg_out_n;
  logic [3:0]  digit_en_n;

  int n_checks = 0;
  int n_fail = 0;

  logic [6:0] digit_m [4];

  seg7_scan_ctrl #(
    .NUM_DIGITS   (4),
    .SCAN_DIV     (SD),
    .BLANK_CYCLES (BC),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .seg_out_n  (seg_out_n),
    .digit_en_n (digit_en_n)
  );

  always #5 clk = ~clk;

  // Expected {digit_en_n, seg_out_n} given t cycles of scanning since enable.
  function automatic logic [10:0] model(input int t, input bit en, input bit blink,
                                        input logic [3:0] mask);
    int idx;
    bit ph;
    logic [3:0] d;
    logic [6:0] s;
    if (!en || (t % SD) < BC) return {4'hF, 7'h7F};
    idx = (t / SD) % 4;
    ph  = ((t / (4 * SD * BF)) % 2) == 1;
    d = 4'hF;
    d[idx] = 1'b0;
    s = (blink && ph && mask[idx]) ? 7'h7F : ~digit_m[idx];
    return {d, s};
  endfunction

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    address = a; #1;
    d = readdata;
  endtask

  task automatic load_digits(input bit fixed);
    for (int i = 0; i < 4; i++) begin
      digit_m[i] = 7'($urandom);
      if (fixed && i == 0) digit_m[i] = 7'h3F;
      if (fixed && i == 1) digit_m[i] = 7'h06;
      bus_write(3'(i), {$urandom} | 32'h0);
      bus_write(3'(i), {25'($urandom), digit_m[i]});
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({digit_en_n, seg_out_n} !== {4'hF, 7'h7F}) begin
        n_fail++;
        $display("FAIL reset_idle cycle %0d: got %h/%h want F/7F", k, digit_en_n, seg_out_n);
      end
    end
    for (int a = 0; a < 8; a++) begin
      bus_read(3'(a), rd);
      n_checks++;
      if (rd !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_read addr %0d: got %h want 0", a, rd);
      end
    end
  endtask

  task automatic test_scan();
    logic [10:0] exp;
    load_digits(1'b1);
    bus_write(3'd4, 32'h1);
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      exp = model(k - 1, 1'b1, 1'b0, 4'h0);
      n_checks++;
      if ({digit_en_n, seg_out_n} !== exp) begin
        n_fail++;
        $display("FAIL scan t=%0d: got %h/%h want %h/%h", k - 1, digit_en_n, seg_out_n,
                 exp[10:7], exp[6:0]);
      end
    end
    bus_write(3'd4, 32'h0);
  endtask

  task automatic test_blink(input logic [3:0] mask0);
    logic [10:0] exp;
    logic [31:0] rd;
    logic [3:0]  mask = mask0;
    logic [3:0]  mask_new = 4'($urandom);
    load_digits(1'b0);
    bus_write(3'd4, {24'd0, mask, 4'h3});
    for (int k = 1; k <= 200; k++) begin
      if (k == 100) bus_write(3'd4, {24'd0, mask_new, 4'h3});
      else begin
        @(posedge clk); #1;
      end
      exp = model(k - 1, 1'b1, 1'b1, mask);
      n_checks++;
      if ({digit_en_n, seg_out_n} !== exp) begin
        n_fail++;
        $display("FAIL blink t=%0d mask=%h: got %h/%h want %h/%h", k - 1, mask,
                 digit_en_n, seg_out_n, exp[10:7], exp[6:0]);
      end
      if (k == 100) mask = mask_new;
      if (k % 23 == 0) begin
        bus_read(3'd5, rd);
        n_checks++;
        if (rd !== {29'd0, 1'(((k / (4 * SD * BF)) % 2)), 2'((k / SD) % 4)}) begin
          n_fail++;
          $display("FAIL status t=%0d: got %h", k, rd);
        end
      end
    end
    bus_write(3'd4, 32'h0);
  endtask

  task automatic test_disable(input int stop_t);
    logic [10:0] exp;
    logic [31:0] rd;
    bus_write(3'd4, 32'h1);
    for (int k = 1; k <= stop_t; k++) begin
      @(posedge clk); #1;
    end
    bus_write(3'd4, 32'h0);
    exp = model(stop_t, 1'b1, 1'b0, 4'h0);
    bus_read(3'd5, rd);
    n_checks += 2;
    if ({digit_en_n, seg_out_n} !== exp) begin
      n_fail++;
      $display("FAIL disable_last t=%0d: got %h/%h want %h/%h", stop_t, digit_en_n,
               seg_out_n, exp[10:7], exp[6:0]);
    end
    if (rd !== 32'd0) begin
      n_fail++;
      $display("FAIL disable_status t=%0d: got %h want 0", stop_t, rd);
    end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({digit_en_n, seg_out_n} !== {4'hF, 7'h7F}) begin
        n_fail++;
        $display("FAIL disable_off: got %h/%h want F/7F", digit_en_n, seg_out_n);
      end
    end
    bus_write(3'd4, 32'h1);
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      exp = model(k - 1, 1'b1, 1'b0, 4'h0);
      n_checks++;
      if ({digit_en_n, seg_out_n} !== exp) begin
        n_fail++;
        $display("FAIL reenable t=%0d: got %h/%h want %h/%h", k - 1, digit_en_n,
                 seg_out_n, exp[10:7], exp[6:0]);
      end
    end
    bus_write(3'd4, 32'h0);
  endtask

  task automatic test_reg_ignore();
    logic [31:0] rd;
    logic [31:0] want [8];
    for (int a = 0; a < 8; a++) begin
      if (a != 4) bus_write(3'(a), 32'hFFFF_FFFF);
    end
    want = '{32'h7F, 32'h7F, 32'h7F, 32'h7F, 32'h0, 32'h0, 32'h0, 32'h0};
    for (int a = 0; a < 8; a++) begin
      bus_read(3'(a), rd);
      n_checks++;
      if (rd !== want[a]) begin
        n_fail++;
        $display("FAIL reg_ignore addr %0d: got %h want %h", a, rd, want[a]);
      end
    end
    bus_write(3'd4, 32'hFFFF_FFFF);
    bus_read(3'd4, rd);
    n_checks++;
    if (rd !== 32'hF3) begin
      n_fail++;
      $display("FAIL ctrl_bits: got %h want F3", rd);
    end
    bus_write(3'd4, 32'h0);
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    bus_write(3'd4, 32'hF3);
    for (int k = 1; k <= 70; k++) begin
      @(posedge clk); #1;
    end
    bus_read(3'd5, rd);
    n_checks++;
    if (rd[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_phase: got %h want phase 1", rd);
    end
    #1 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({digit_en_n, seg_out_n} !== {4'hF, 7'h7F}) begin
      n_fail++;
      $display("FAIL reset_async: got %h/%h want F/7F", digit_en_n, seg_out_n);
    end
    @(posedge clk); #3 reset_n = 1'b1;
    for (int a = 0; a < 6; a++) begin
      bus_read(3'(a), rd);
      n_checks++;
      if (rd !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_mid_read addr %0d: got %h want 0", a, rd);
      end
    end
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({digit_en_n, seg_out_n} !== {4'hF, 7'h7F}) begin
        n_fail++;
        $display("FAIL reset_mid_off: got %h/%h want F/7F", digit_en_n, seg_out_n);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) digit_m[i] = 7'd0;
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b1;
    test_reset();
    test_scan();
    test_blink(4'h1);
    test_blink(4'($urandom));
    test_disable(20);
    test_disable(7);
    test_reg_ignore();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
